// File: rtl/ariane_host_pkg.sv
// Shared definitions for the host monitor and its host-side consumer:
// FSM state encoding and the ecall cause codes that terminate a run.
package ariane_host_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } host_state_e;

    localparam logic [63:0] CAUSE_USER_ECALL       = 64'h8;
    localparam logic [63:0] CAUSE_SUPERVISOR_ECALL = 64'h9;
    localparam logic [63:0] CAUSE_MACHINE_ECALL    = 64'hB;

    function automatic logic is_ecall(input logic [63:0] cause);
        return (cause == CAUSE_USER_ECALL) || (cause == CAUSE_SUPERVISOR_ECALL) ||
               (cause == CAUSE_MACHINE_ECALL);
    endfunction

endpackage

// File: rtl/ariane_host_monitor.sv
// Host monitor: counts cycles and retired instructions from the first core activity,
// forwards exceptions to the host as one-cycle pulses and stops on an ecall.
module ariane_host_monitor
    import ariane_host_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NrCommitPorts-1:0] commit_ack_i,
    input  logic                     ex_valid_i,
    input  logic [63:0]              ex_cause_i,
    output logic                     ex_o,
    output logic [63:0]              cause_o,
    output logic [63:0]              cycle_o,
    output logic [63:0]              instret_o,
    output logic                     done_o
);

    host_state_e state_q;
    logic        ex_q;
    logic        done_q;
    logic [63:0] cause_q;
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    logic [63:0] retire_cnt;
    logic        start_evt;
    logic        count_en;

    always_comb begin
        retire_cnt = '0;
        for (int unsigned i = 0; i < NrCommitPorts; i++) begin
            retire_cnt = retire_cnt + 64'(commit_ack_i[i]);
        end
    end

    assign start_evt = (|commit_ack_i) | ex_valid_i;
    // The entry edge out of IDLE already counts, so cycle_o reads 1 right after it.
    assign count_en  = (state_q == StRun) | ((state_q == StIdle) & start_evt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ex_q      <= 1'b0;
            done_q    <= 1'b0;
            cause_q   <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    if (count_en) begin
                        cycle_q   <= cycle_q + 64'd1;
                        instret_q <= instret_q + retire_cnt;
                    end
                    ex_q <= ex_valid_i;
                    if (ex_valid_i) begin
                        cause_q <= ex_cause_i;
                    end
                    if (ex_valid_i && is_ecall(ex_cause_i)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (start_evt) begin
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    ex_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ex_o      = ex_q;
    assign cause_o   = cause_q;
    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_ariane_host_monitor.sv
// Randomised self-checking bench for ariane_host_monitor against a behavioural model.
module tb_ariane_host_monitor;

    localparam int unsigned NrCommitPorts = 2;

    logic                     clk_i;
    logic                     rst_ni;
    logic [NrCommitPorts-1:0] commit_ack_i;
    logic                     ex_valid_i;
    logic [63:0]              ex_cause_i;
    logic                     ex_o;
    logic [63:0]              cause_o;
    logic [63:0]              cycle_o;
    logic [63:0]              instret_o;
    logic                     done_o;

    ariane_host_monitor #(
        .NrCommitPorts(NrCommitPorts)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .commit_ack_i(commit_ack_i),
        .ex_valid_i  (ex_valid_i),
        .ex_cause_i  (ex_cause_i),
        .ex_o        (ex_o),
        .cause_o     (cause_o),
        .cycle_o     (cycle_o),
        .instret_o   (instret_o),
        .done_o      (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: "started" means activity has been seen since reset.
    bit          m_started;
    bit          m_done;
    bit          m_ex;
    logic [63:0] m_cause;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ex"},      64'(ex_o),   64'(m_ex));
        chk({tag, ".cause"},   cause_o,     m_cause);
        chk({tag, ".cycle"},   cycle_o,     m_cycle);
        chk({tag, ".instret"}, instret_o,   m_instret);
        chk({tag, ".done"},    64'(done_o), 64'(m_done));
    endtask

    function automatic bit model_is_ecall(input logic [63:0] c);
        return c == 64'h8 || c == 64'h9 || c == 64'hB;
    endfunction

    task automatic model_reset();
        m_started = 0; m_done = 0; m_ex = 0;
        m_cause = '0; m_cycle = '0; m_instret = '0;
    endtask

    task automatic model_step(input logic [NrCommitPorts-1:0] ack, input bit ex,
                              input logic [63:0] cause);
        if (m_done) begin
            m_ex = 0;
            return;
        end
        if (m_started || ack != 0 || ex) begin
            m_started = 1;
            m_cycle   = m_cycle + 64'd1;
            m_instret = m_instret + 64'($countones(ack));
        end
        m_ex = ex;
        if (ex) begin
            m_cause = cause;
            if (model_is_ecall(cause)) m_done = 1;
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic step(input logic [NrCommitPorts-1:0] ack, input bit ex,
                        input logic [63:0] cause, input string tag);
        commit_ack_i = ack;
        ex_valid_i   = ex;
        ex_cause_i   = cause;
        @(posedge clk_i);
        model_step(ack, ex, cause);
        #1;
        chk_all(tag);
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic apply_reset(input string tag);
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk_all(tag);
        @(negedge clk_i);
        @(negedge clk_i);
        chk_all({tag, ".held"});
        commit_ack_i = '0;
        ex_valid_i   = 1'b0;
        ex_cause_i   = '0;
        rst_ni       = 1'b1;
    endtask

    function automatic logic [63:0] rand_cause();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 64'h8;
            1: return 64'h9;
            2: return 64'hB;
            3: return 64'h2;
            4: return 64'h5;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        rst_ni       = 1'b1;
        commit_ack_i = '0;
        ex_valid_i   = 1'b0;
        ex_cause_i   = '0;
        #2;
        apply_reset("rst0");

        // Idle gap then first retire pair starts the run.
        for (int i = 0; i < 5; i++) step(2'b00, 0, 64'h0, "idle");
        step(2'b11, 0, 64'h0, "start");
        chk("start.cycle_is_1", cycle_o, 64'd1);
        chk("start.instret_is_2", instret_o, 64'd2);
        for (int i = 0; i < 10; i++) step(2'b01, 0, 64'h0, "run");
        step(2'b11, 1, 64'hB, "mecall");
        chk("mecall.done", 64'(done_o), 64'd1);
        for (int i = 0; i < 4; i++)
            step(2'(i), (i % 2) == 0, 64'h2, "frozen");

        // Ecall as the very first event.
        apply_reset("rst1");
        step(2'b00, 1, 64'h8, "first_ecall");
        chk("first_ecall.cycle_is_1", cycle_o, 64'd1);
        step(2'b11, 1, 64'h5, "after_ecall");

        // Back-to-back non-ecall exceptions stay in RUN.
        apply_reset("rst2");
        step(2'b01, 0, 64'h0, "b2b.pre");
        step(2'b00, 1, 64'h2, "b2b.a");
        step(2'b10, 1, 64'h5, "b2b.b");
        step(2'b01, 0, 64'h0, "b2b.post");
        step(2'b01, 0, 64'h0, "b2b.post2");

        // Instret wrap at 2^64.
        @(negedge clk_i);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        step(2'b11, 0, 64'h0, "wrap");
        chk("wrap.instret_is_1", instret_o, 64'd1);

        // Mid-cycle reset during RUN, then recover as from a fresh reset.
        for (int i = 0; i < 3; i++) step(2'b11, 0, 64'h0, "prerst");
        #3;
        apply_reset("midrst");
        step(2'b00, 0, 64'h0, "rec.idle");
        step(2'b11, 0, 64'h0, "rec.start");

        // Randomised runs, each from reset.
        for (int r = 0; r < 8; r++) begin
            apply_reset("rnd.rst");
            for (int i = 0; i < 60; i++) begin
                logic [NrCommitPorts-1:0] ack;
                bit                       ex;
                ack = NrCommitPorts'($urandom());
                if ($urandom_range(0, 3) == 0) ack = '0;
                ex  = ($urandom_range(0, 7) == 0);
                step(ack, ex, rand_cause(), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
